// File: rtl/apb_timer8_prescaled_if.sv
// APB slave bus bundle for apb_timer8_prescaled.
// Handshake: the master raises psel for the setup phase, then psel & penable
// for the access phase. The slave answers with pready in that same cycle
// (zero wait states), so every cycle with psel & penable high is one complete
// transfer. Holding both high for several cycles gives back-to-back transfers.
// pready is low whenever no access phase is in progress.
interface apb_timer8_prescaled_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_timer8_prescaled.sv
// 8-bit up/down timer with an APB register interface and a free-running
// prescaler (pclk/2, /4, /8, /16).
// Registers: 0 TCNT (ro), 1 TSR (w1c flags), 2 TDR (reload), 3 TCR (control).
// Optional macro TMR_PSLVERR_EN: when defined, writes to TCNT and any access
// to addresses 4..7 raise pslverr and have no effect.
module apb_timer8_prescaled #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int PRESC_WIDTH = 4
) (
   input  logic                 pclk,
   input  logic                 preset_n,
   apb_timer8_prescaled_if.slave apb,
   output logic                 TMR_OVF,
   output logic                 TMR_UDF
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TCNT = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TSR  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TDR  = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TCR  = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(3);
   // Writable TCR bits: LOAD(7), DOWN(5), EN(4), CKS(1:0).
   localparam logic [DATA_WIDTH-1:0] TCR_MASK  = DATA_WIDTH'(8'hB3);

   logic [PRESC_WIDTH-1:0] pre;
   logic [PRESC_WIDTH-1:0] tick;
   logic [DATA_WIDTH-1:0]  tcnt;
   logic [DATA_WIDTH-1:0]  tdr;
   logic [DATA_WIDTH-1:0]  tcr;
   logic                   ovf;
   logic                   udf;

   logic       access;
   logic       access_err;
   logic       wr_ok;
   logic       tcr_load;
   logic       tcr_down;
   logic       tcr_en;
   logic [1:0] tcr_cks;
   logic       step;
   logic       wrap_up;
   logic       wrap_dn;
   logic       clr_ovf;
   logic       clr_udf;

   assign access = apb.psel & apb.penable;

`ifdef TMR_PSLVERR_EN
   assign access_err = access & ((apb.paddr > ADDR_LAST) |
                                 (apb.pwrite & (apb.paddr == ADDR_TCNT)));
`else
   assign access_err = 1'b0;
`endif

   assign apb.pready  = access;
   assign apb.pslverr = access_err;
   assign wr_ok       = access & apb.pwrite & ~access_err;

   assign tcr_load = tcr[7];
   assign tcr_down = tcr[5];
   assign tcr_en   = tcr[4];
   assign tcr_cks  = tcr[1:0];

   // Free-running prescaler; bit k is the divided clock clk_k.
   always_ff @(posedge pclk) begin
      if (!preset_n) pre <= '0;
      else           pre <= pre + PRESC_WIDTH'(1);
   end

   // tick[k] marks the cycle just before clk_k rises: pre[k] low, lower bits all ones.
   always_comb begin
      tick = '0;
      for (int k = 0; k < PRESC_WIDTH; k++) begin
         logic t;
         t = ~pre[k];
         for (int j = 0; j < k; j++) t = t & pre[j];
         tick[k] = t;
      end
   end

   assign step    = tcr_en & tick[tcr_cks] & ~tcr_load;
   assign wrap_up = step & ~tcr_down & (tcnt == '1);
   assign wrap_dn = step &  tcr_down & (tcnt == '0);
   assign clr_ovf = wr_ok & (apb.paddr == ADDR_TSR) & apb.pwdata[0];
   assign clr_udf = wr_ok & (apb.paddr == ADDR_TSR) & apb.pwdata[1];

   // Counter: LOAD copies TDR every cycle and blocks counting; otherwise step on the selected tick.
   always_ff @(posedge pclk) begin
      if (!preset_n)     tcnt <= '0;
      else if (tcr_load) tcnt <= tdr;
      else if (step)     tcnt <= tcr_down ? tcnt - DATA_WIDTH'(1) : tcnt + DATA_WIDTH'(1);
   end

   // Reload and control registers written from the bus.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         tdr <= '0;
         tcr <= '0;
      end else begin
         if (wr_ok && apb.paddr == ADDR_TDR) tdr <= apb.pwdata;
         if (wr_ok && apb.paddr == ADDR_TCR) tcr <= apb.pwdata & TCR_MASK;
      end
   end

   // Sticky wrap flags; a wrap in the same cycle as a clear keeps the flag set.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         ovf <= wrap_up | (ovf & ~clr_ovf);
         udf <= wrap_dn | (udf & ~clr_udf);
      end
   end

   assign TMR_OVF = ovf;
   assign TMR_UDF = udf;

   // Read mux: data only during a selected read, zero otherwise.
   always_comb begin
      apb.prdata = '0;
      if (apb.psel && !apb.pwrite && !access_err) begin
         case (apb.paddr)
            ADDR_TCNT: apb.prdata = tcnt;
            ADDR_TSR:  apb.prdata = {{(DATA_WIDTH-2){1'b0}}, udf, ovf};
            ADDR_TDR:  apb.prdata = tdr;
            ADDR_TCR:  apb.prdata = tcr;
            default:   apb.prdata = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_timer8_prescaled.sv
// Self-checking bench for apb_timer8_prescaled.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_apb_timer8_prescaled;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef TMR_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic tmr_ovf, tmr_udf;
  always #5 pclk = ~pclk;

  apb_timer8_prescaled_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

  apb_timer8_prescaled dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .apb     (apb),
    .TMR_OVF (tmr_ovf),
    .TMR_UDF (tmr_udf)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Timer state as the register map describes it; prescaler phase is derived
  // from the number of clock edges since reset.
  logic [7:0]  m_cnt, m_tdr, m_tcr;
  logic        m_ovf, m_udf;
  int unsigned m_cyc;

  function automatic bit model_err(logic s, logic e, logic w, logic [2:0] a);
    return ERR_EN && s && e && (a >= 3'd4 || (w && a == 3'd0));
  endfunction

  function automatic logic [7:0] exp_prdata(logic s, logic w, logic [2:0] a);
    if (!(s && !w)) return 8'h00;
    case (a)
      3'd0:    return m_cnt;
      3'd1:    return {6'b0, m_udf, m_ovf};
      3'd2:    return m_tdr;
      3'd3:    return m_tcr;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge pclk) begin : model
    int unsigned period, half;
    bit          tick, err, wr, set_o, set_u, clr_o, clr_u;
    logic [7:0]  nxt;
    if (!preset_n) begin
      m_cnt <= 8'h00; m_tdr <= 8'h00; m_tcr <= 8'h00;
      m_ovf <= 1'b0;  m_udf <= 1'b0;  m_cyc <= 0;
    end else begin
      period = 32'd2 << m_tcr[1:0];          // clk_k period in pclk cycles
      half   = period / 2;
      tick   = ((m_cyc % period) == (half - 1));
      err    = model_err(apb.psel, apb.penable, apb.pwrite, apb.paddr);
      wr     = apb.psel && apb.penable && apb.pwrite && !err;
      set_o = 0; set_u = 0;
      nxt = m_cnt;
      if (m_tcr[7]) nxt = m_tdr;
      else if (m_tcr[4] && tick) begin
        if (m_tcr[5]) begin set_u = (m_cnt == 8'h00); nxt = 8'((int'(m_cnt) + 255) % 256); end
        else          begin set_o = (m_cnt == 8'hFF); nxt = 8'((int'(m_cnt) + 1) % 256);   end
      end
      clr_o = wr && apb.paddr == 3'd1 && apb.pwdata[0];
      clr_u = wr && apb.paddr == 3'd1 && apb.pwdata[1];
      m_cnt <= nxt;
      m_ovf <= set_o || (m_ovf && !clr_o);
      m_udf <= set_u || (m_udf && !clr_u);
      if (wr && apb.paddr == 3'd2) m_tdr <= apb.pwdata;
      if (wr && apb.paddr == 3'd3) m_tcr <= apb.pwdata & 8'hB3;
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic s, input logic e, input logic w,
                     input logic [2:0] a, input logic [7:0] d);
    @(negedge pclk);
    apb.psel = s; apb.penable = e; apb.pwrite = w; apb.paddr = a; apb.pwdata = d;
    #1;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    cyc(1, 0, 1, a, d);
    cyc(1, 1, 1, a, d);
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic [7:0] e);
    cyc(1, 0, 0, a, 8'h00);
    cyc(1, 1, 0, a, 8'h00);
    d = apb.prdata;
    e = exp_prdata(1'b1, 1'b0, a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d, e;
    preset_n = 1'b0;
    repeat (3) cyc(0, 0, 0, 3'd0, 8'h00);
    checks++; if (apb.pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b expected 0", apb.pready); end
    checks++; if (tmr_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", tmr_ovf); end
    checks++; if (tmr_udf !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b expected 0", tmr_udf); end
    preset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      apb_read(3'(a), d, e);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", a, d); end
    end
    cyc(0, 0, 0, 3'd0, 8'h00);
    checks++; if (apb.pready !== 1'b0 || apb.prdata !== 8'h00) begin errors++; $display("FAIL idle_bus: got pready %b prdata %h expected 0 00", apb.pready, apb.prdata); end
  endtask

  task automatic test_up_count();
    logic [7:0] d, e, prev;
    int last_chg, saw_wrap;
    apb_write(3'd2, 8'hF0);
    apb_write(3'd3, 8'h83);
    cyc(0, 0, 0, 3'd0, 8'h00);
    cyc(0, 0, 0, 3'd0, 8'h00);
    apb_write(3'd3, 8'h13);
    prev = 8'hF0; last_chg = -1; saw_wrap = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 3'd0, 8'h00);
      d = apb.prdata;
      checks++; if (d !== m_cnt) begin errors++; $display("FAIL up_cnt: cycle %0d got %h expected %h", i, d, m_cnt); end
      checks++; if (tmr_ovf !== m_ovf) begin errors++; $display("FAIL up_ovf: cycle %0d got %b expected %b", i, tmr_ovf, m_ovf); end
      if (d !== prev) begin
        checks++; if (d !== 8'(prev + 8'd1)) begin errors++; $display("FAIL up_step: got %h expected %h", d, 8'(prev + 8'd1)); end
        if (last_chg >= 0) begin
          checks++; if (i - last_chg != 16) begin errors++; $display("FAIL up_period: got %0d expected 16", i - last_chg); end
        end
        if (d == 8'h00 && saw_wrap == 0) begin
          saw_wrap = 1;
          checks++; if (tmr_ovf !== 1'b1) begin errors++; $display("FAIL up_wrap_flag: got %b expected 1", tmr_ovf); end
        end
        last_chg = i; prev = d;
      end
    end
    checks++; if (saw_wrap != 1) begin errors++; $display("FAIL up_wrap_seen: got %0d expected 1", saw_wrap); end
    apb_read(3'd1, d, e);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL up_tsr: got %h expected 01", d); end
    apb_read(3'd3, d, e);
    checks++; if (d !== 8'h13) begin errors++; $display("FAIL up_tcr: got %h expected 13", d); end
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic test_clear();
    int saw;
    apb_write(3'd1, 8'h00);
    checks++; if (tmr_ovf !== 1'b1) begin errors++; $display("FAIL clr_zero_write: got %b expected 1", tmr_ovf); end
    cyc(1, 0, 1, 3'd1, 8'h01);
    cyc(1, 1, 1, 3'd1, 8'h01);
    cyc(0, 0, 0, 3'd0, 8'h00);
    checks++; if (tmr_ovf !== 1'b0) begin errors++; $display("FAIL clr_next_cycle: got %b expected 0", tmr_ovf); end
    // Wrap while TSR=1 is being written every cycle: the set must win once.
    apb_write(3'd3, 8'h00);
    apb_write(3'd2, 8'hFC);
    apb_write(3'd3, 8'h90);
    apb_write(3'd3, 8'h10);
    saw = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1, 1, 1, 3'd1, 8'h01);
      if (tmr_ovf === 1'b1) saw++;
      checks++; if (tmr_ovf !== m_ovf) begin errors++; $display("FAIL clr_race_ovf: cycle %0d got %b expected %b", i, tmr_ovf, m_ovf); end
    end
    cyc(0, 0, 0, 3'd0, 8'h00);
    checks++; if (saw != 1) begin errors++; $display("FAIL clr_set_wins: got %0d cycles expected 1", saw); end
    checks++; if (tmr_ovf !== 1'b0) begin errors++; $display("FAIL clr_after_race: got %b expected 0", tmr_ovf); end
  endtask

  task automatic test_down_count();
    logic [7:0] d, prev;
    int last_chg, saw_ff;
    apb_write(3'd3, 8'h00);
    apb_write(3'd2, 8'h02);
    apb_write(3'd3, 8'hA0);
    apb_write(3'd3, 8'h30);
    prev = 8'h02; last_chg = -1; saw_ff = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, 3'd0, 8'h00);
      d = apb.prdata;
      checks++; if (d !== m_cnt) begin errors++; $display("FAIL dn_cnt: cycle %0d got %h expected %h", i, d, m_cnt); end
      checks++; if (tmr_udf !== m_udf) begin errors++; $display("FAIL dn_udf: cycle %0d got %b expected %b", i, tmr_udf, m_udf); end
      checks++; if (tmr_ovf !== 1'b0) begin errors++; $display("FAIL dn_ovf: cycle %0d got %b expected 0", i, tmr_ovf); end
      if (d !== prev) begin
        checks++; if (d !== 8'(prev - 8'd1)) begin errors++; $display("FAIL dn_step: got %h expected %h", d, 8'(prev - 8'd1)); end
        if (last_chg >= 0) begin
          checks++; if (i - last_chg != 2) begin errors++; $display("FAIL dn_period: got %0d expected 2", i - last_chg); end
        end
        if (d == 8'hFF) begin
          saw_ff = 1;
          checks++; if (tmr_udf !== 1'b1) begin errors++; $display("FAIL dn_udf_on_ff: got %b expected 1", tmr_udf); end
        end
        last_chg = i; prev = d;
      end else if (saw_ff == 0) begin
        checks++; if (tmr_udf !== 1'b0) begin errors++; $display("FAIL dn_udf_early: got %b expected 0", tmr_udf); end
      end
    end
    checks++; if (saw_ff != 1) begin errors++; $display("FAIL dn_reach_ff: got %0d expected 1", saw_ff); end
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic test_hold_resume();
    logic [7:0] d;
    int found;
    apb_write(3'd1, 8'h03);
    apb_write(3'd2, 8'h3E);
    apb_write(3'd3, 8'h93);
    apb_write(3'd3, 8'h13);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      cyc(1, 1, 0, 3'd0, 8'h00);
      if (apb.prdata === 8'h40) found = 1;
    end
    checks++; if (found != 1) begin errors++; $display("FAIL hold_reach_40: got %0d expected 1", found); end
    apb_write(3'd3, 8'h03);
    for (int i = 0; i < 70; i++) begin
      cyc(1, 1, 0, 3'd0, 8'h00);
      d = apb.prdata;
      checks++; if (d !== 8'h40) begin errors++; $display("FAIL hold_value: cycle %0d got %h expected 40", i, d); end
    end
    apb_write(3'd3, 8'h13);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, 3'd0, 8'h00);
      d = apb.prdata;
      checks++; if (d !== m_cnt) begin errors++; $display("FAIL resume_cnt: cycle %0d got %h expected %h", i, d, m_cnt); end
    end
    checks++; if (!(d > 8'h40 && d <= 8'h43)) begin errors++; $display("FAIL resume_progress: got %h expected 41..43", d); end
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic test_pslverr();
    logic [7:0] d, e, tdr0;
    tdr0 = m_tdr;
    cyc(1, 0, 1, 3'd5, 8'hAA);
    cyc(1, 1, 1, 3'd5, 8'hAA);
    checks++; if (apb.pslverr !== ERR_EN || apb.pready !== 1'b1) begin errors++; $display("FAIL err_wr_unmapped: got %b/%b expected %b/1", apb.pslverr, apb.pready, ERR_EN); end
    cyc(1, 0, 1, 3'd0, 8'h55);
    cyc(1, 1, 1, 3'd0, 8'h55);
    checks++; if (apb.pslverr !== ERR_EN) begin errors++; $display("FAIL err_wr_tcnt: got %b expected %b", apb.pslverr, ERR_EN); end
    cyc(1, 0, 0, 3'd6, 8'h00);
    cyc(1, 1, 0, 3'd6, 8'h00);
    checks++; if (apb.prdata !== 8'h00 || apb.pslverr !== ERR_EN) begin errors++; $display("FAIL err_rd_unmapped: got %h/%b expected 00/%b", apb.prdata, apb.pslverr, ERR_EN); end
    apb_read(3'd0, d, e);
    checks++; if (d !== e || apb.pslverr !== 1'b0) begin errors++; $display("FAIL err_tcnt_intact: got %h/%b expected %h/0", d, apb.pslverr, e); end
    apb_read(3'd2, d, e);
    checks++; if (d !== tdr0) begin errors++; $display("FAIL err_tdr_intact: got %h expected %h", d, tdr0); end
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic test_random();
    logic s, e, w;
    logic [2:0] a;
    logic [7:0] d;
    for (int i = 0; i < 800; i++) begin
      preset_n = (i == 400) ? 1'b0 : 1'b1;
      s = ($urandom_range(0, 9) > 2);
      e = s && ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 3'd3 && $urandom_range(0, 4) != 0) d = d & 8'h7F;
      if (a == 3'd2) begin
        case ($urandom_range(0, 4))
          0: d = 8'h00;
          1: d = 8'h01;
          2: d = 8'hFE;
          3: d = 8'hFF;
          default: ;
        endcase
      end
      cyc(s, e, w, a, d);
      checks++; if (apb.prdata !== exp_prdata(s, w, a)) begin errors++; $display("FAIL rnd_prdata: cycle %0d got %h expected %h", i, apb.prdata, exp_prdata(s, w, a)); end
      checks++; if (apb.pready !== (s && e)) begin errors++; $display("FAIL rnd_pready: cycle %0d got %b expected %b", i, apb.pready, s && e); end
      checks++; if (apb.pslverr !== model_err(s, e, w, a)) begin errors++; $display("FAIL rnd_pslverr: cycle %0d got %b expected %b", i, apb.pslverr, model_err(s, e, w, a)); end
      checks++; if (tmr_ovf !== m_ovf || tmr_udf !== m_udf) begin errors++; $display("FAIL rnd_flags: cycle %0d got %b%b expected %b%b", i, tmr_ovf, tmr_udf, m_ovf, m_udf); end
    end
    preset_n = 1'b1;
    cyc(0, 0, 0, 3'd0, 8'h00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 3'd0; apb.pwdata = 8'h00;
    test_reset();
    test_up_count();
    test_clear();
    test_down_count();
    test_hold_resume();
    test_pslverr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_timer8_prescaled.md
Name: apb_timer8_prescaled

Overview:
- 8-bit up/down timer/counter with APB slave register interface and integrated 4-stage clock prescaler.
- Prescaler divides pclk by 2/4/8/16. The timer counts selected prescaler ticks, loads from a data register, and flags overflow/underflow.
- Peripheral-level block on the APB bus; the flags feed the interrupt/status logic.

Parameters:
- DATA_WIDTH, 8, APB data and counter width (fixed at 8).
- ADDR_WIDTH, 3, APB address width.
- PRESC_WIDTH, 4, prescaler counter width (one divided clock per bit).

Ports:
- pclk  input  1  single clock for all logic.
- preset_n  input  1  reset, synchronous, active-low.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  register address.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer ready.
- pslverr  output  1  transfer error.
- TMR_OVF  output  1  sticky overflow flag.
- TMR_UDF  output  1  sticky underflow flag.

Behaviour:
- Reset (preset_n=0 at pclk rising edge): prescaler, TCNT, TDR, TCR, TSR and TMR_OVF/TMR_UDF all clear to 0. pclk is the only clock; preset_n is synchronous and active-low.
- Prescaler: free-running PRESC_WIDTH counter, +1 every pclk. Divided clock clk_k = pre[k], giving period 2^(k+1) pclk.
- tick_k is asserted in the single cycle where pre[k:0] == {1'b0, k ones}, so the counter updates coincide with each clk_k rising edge.
- APB transfers:
  - Zero wait states: pready = psel & penable; pready = 0 when idle.
  - A write commits at the pclk edge when psel & penable & pwrite.
  - Read: prdata = selected register when psel & !pwrite, else 0.
  - psel/penable may be held high continuously; every such cycle is a full access.
- Register map:
  - 0x0 TCNT: read-only, current count.
  - 0x1 TSR: bit0 OVF, bit1 UDF; write-1-to-clear; other bits read 0.
  - 0x2 TDR: R/W, reload value.
  - 0x3 TCR: R/W. bit7 LOAD, bit5 DOWN (0 = up, 1 = down), bit4 EN, bits1:0 CKS (00 = /2, 01 = /4, 10 = /8, 11 = /16). Bits 6, 3, 2 are read-only 0.
  - 0x4–0x7: unmapped.
- Counter priority, per cycle:
  1. LOAD = 1: TCNT <= TDR every cycle. Counting is inhibited while LOAD is set.
  2. Else EN & tick_CKS: TCNT +1 (up) or -1 (down), mod 256.
  3. Else hold.
- Overflow: up-count from 0xFF to 0x00 sets TSR.OVF. Underflow: down-count from 0x00 to 0xFF sets TSR.UDF.
- Flag timing: flags set on the same edge TCNT wraps. TMR_OVF = TSR.OVF and TMR_UDF = TSR.UDF, both registered.
- Flags stay set until cleared by a TSR write. If set and clear happen in the same cycle, set wins.
- LOAD is not a wrap: a load never sets a flag.
- Changing TDR while LOAD = 0 does not affect TCNT.
- Changing CKS or EN mid-count takes effect on the next cycle. The count is retained and the prescaler is not reset.
- Reset asserted mid-count: everything clears on that edge.
- Time to wrap after LOAD drops with EN = 1: (256 − TDR) ticks (up) or (TDR + 1) ticks (down).

Optional Feature:
- Macro TMR_PSLVERR_EN.
- Defined: pslverr = psel & penable & (paddr ≥ 4 or (pwrite & paddr == 0)). Erroring writes change no state; erroring reads return 0.
- Undefined: pslverr tied 0. Writes to unmapped or read-only addresses are silently ignored; reads of them return 0.

Test Plan:
- Reset then read all 4 registers -> all 0x00; TMR_OVF = TMR_UDF = 0; pready = 0 when idle.
- Write TDR = 0xF0; TCR = 0x83 for 2 cycles, then TCR = 0x13 -> TCNT reads 0xF0, then increments once per 16 pclk. After 16 ticks TCNT = 0x00, TMR_OVF = 1, TSR = 0x01.
- Write TDR = 0x02; TCR = 0xA0, then TCR = 0x30 (down, /2) -> TCNT 0x02→0x01→0x00→0xFF, one step per 2 pclk. TMR_UDF = 1 on the 0xFF step; TMR_OVF stays 0.
- With OVF set, write TSR = 0x01 -> TMR_OVF = 0 next cycle. Write TSR = 0x00 -> no change. Wrap in the same cycle as the clear -> flag stays 1.
- Counting at TCNT = 0x40, write TCR = 0x03 (EN = 0) -> TCNT holds 0x40 for ≥ 64 cycles. Writing TCR = 0x13 resumes from 0x40.
- TMR_PSLVERR_EN defined: write paddr = 3'b101 or paddr = 0 -> pslverr = 1 during access, no register change. Read paddr = 3'b110 -> prdata = 0, pslverr = 1. Undefined: pslverr = 0 in both cases.
